fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC register and the icache request (iREN/imemaddr), and it presents instruction and PC+4 to the IF/ID register's inputs together with that register's enable and flush controls. It accepts stall from the hazard unit and PC redirects from branch/jump resolution, and it stops fetching after a HALT instruction is fetched.

---
 rtl/fetch_stage_if.sv | 38 +++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: icache request/response, hazard/redirect controls and IF/ID drive.
// FETCH_PERF_EN adds the fetch_count/stall_count performance outputs.
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pcplus4;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc,
    output iREN, imemaddr, ifid_instruction, ifid_pcplus4,
           ifid_enable, ifid_flush, halted
`ifdef FETCH_PERF_EN
    , output fetch_count, stall_count
`endif
  );

  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc,
    input  iREN, imemaddr, ifid_instruction, ifid_pcplus4,
           ifid_enable, ifid_flush, halted
`ifdef FETCH_PERF_EN
    , input fetch_count, stall_count
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC and icache request, drives IF/ID inputs and controls.
// Define FETCH_PERF_EN to add fetch/stall performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic          CLK,
  input logic          nRST,
  fetch_stage_if.master bus
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic        enable, flush;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Priority: redirect > stall > fetch; default is a bubble into IF/ID.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    enable     = 1'b1;
    flush      = 1'b1;
    if (bus.redirect) begin
      pc_next    = bus.redirect_pc;
      state_next = RUN;
    end else if (bus.stall) begin
      enable = 1'b0;
      flush  = 1'b0;
    end else if (state == RUN && bus.ihit) begin
      pc_next = pc_plus4;
      flush   = 1'b0;
      if (bus.imemload == HALT_WORD) state_next = HALTED;
    end
  end

  assign bus.iREN             = (state == RUN);
  assign bus.imemaddr         = pc;
  assign bus.ifid_instruction = bus.imemload;
  assign bus.ifid_pcplus4     = pc_plus4;
  assign bus.halted           = (state == HALTED);
  // IF/ID is held flushed and not loading while reset is asserted.
  assign bus.ifid_enable      = nRST & enable;
  assign bus.ifid_flush       = ~nRST | flush;

`ifdef FETCH_PERF_EN
  logic        accept, stall_cycle;
  logic [31:0] fetch_count, stall_count;

  assign accept      = (state == RUN) & bus.ihit & ~bus.stall & ~bus.redirect;
  assign stall_cycle = (state == RUN) & ~bus.redirect & (bus.stall | ~bus.ihit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept)      fetch_count <= fetch_count + 32'd1;
      if (stall_cycle) stall_count <= stall_count + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_count;
  assign bus.stall_count = stall_count;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected outputs queued at drive time, checked at negedge.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic CLK;
  logic nRST;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC), .HALT_WORD(HALT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  typedef struct {
    logic        iren;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        en;
    logic        fl;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_fetch, m_stall;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("iREN",   {31'd0, bus.iREN},        {31'd0, e.iren});
      check("addr",   bus.imemaddr,             e.addr);
      check("instr",  bus.ifid_instruction,     e.instr);
      check("pcp4",   bus.ifid_pcplus4,         e.pcp4);
      check("enable", {31'd0, bus.ifid_enable}, {31'd0, e.en});
      check("flush",  {31'd0, bus.ifid_flush},  {31'd0, e.fl});
      check("halted", {31'd0, bus.halted},      {31'd0, e.halted});
    end
  end

  // Called at posedge+1; drives one cycle, queues its expectation, returns at next posedge+1.
  task automatic cycle(input logic ih, input logic [31:0] ld, input logic st,
                       input logic rd, input logic [31:0] rpc);
    exp_t e;
    bus.ihit = ih; bus.imemload = ld; bus.stall = st;
    bus.redirect = rd; bus.redirect_pc = rpc;
    e.iren = ~m_halted; e.addr = m_pc; e.instr = ld; e.pcp4 = m_pc + 32'd4;
    e.halted = m_halted;
    if (rd)            begin e.en = 1'b1; e.fl = 1'b1; end
    else if (st)       begin e.en = 1'b0; e.fl = 1'b0; end
    else if (m_halted) begin e.en = 1'b1; e.fl = 1'b1; end
    else if (ih)       begin e.en = 1'b1; e.fl = 1'b0; end
    else               begin e.en = 1'b1; e.fl = 1'b1; end
    sb.push_back(e);
    if (!m_halted && !rd && ih && !st) m_fetch = m_fetch + 32'd1;
    if (!m_halted && !rd && (st || !ih)) m_stall = m_stall + 32'd1;
    if (rd) begin
      m_pc = rpc; m_halted = 1'b0;
    end else if (!st && !m_halted && ih) begin
      if (ld == HALT) m_halted = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    @(posedge CLK); #1;
  endtask

  // Asserts reset mid-cycle (no clock edge needed), checks, releases at posedge+1.
  task automatic do_reset();
    nRST = 1'b0;
    bus.ihit = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    bus.redirect_pc = '0; bus.imemload = 32'hDEAD_BEEF;
    #1;
    check("rst_iREN",   {31'd0, bus.iREN},        32'd1);
    check("rst_addr",   bus.imemaddr,             RST_PC);
    check("rst_enable", {31'd0, bus.ifid_enable}, 32'd0);
    check("rst_flush",  {31'd0, bus.ifid_flush},  32'd1);
    check("rst_halted", {31'd0, bus.halted},      32'd0);
    check("rst_instr",  bus.ifid_instruction,     32'hDEAD_BEEF);
    check("rst_pcp4",   bus.ifid_pcplus4,         RST_PC + 32'd4);
`ifdef FETCH_PERF_EN
    check("rst_fcnt", bus.fetch_count, 32'd0);
    check("rst_scnt", bus.stall_count, 32'd0);
`endif
    m_pc = RST_PC; m_halted = 1'b0; m_fetch = '0; m_stall = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1;
    #2;
    do_reset();

    // Sequential fetch
    cycle(1'b1, 32'h2001_0005, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h2002_0007, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h0022_1820, 1'b0, 1'b0, '0);
    check("seq_pc12", bus.imemaddr, 32'd12);

    // Stall holds PC, release accepts
    cycle(1'b1, 32'h1111_1111, 1'b1, 1'b0, '0);
    cycle(1'b1, 32'h1111_1111, 1'b1, 1'b0, '0);
    check("stall_pc", bus.imemaddr, 32'd12);
    cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0, '0);
    check("stall_rel_pc", bus.imemaddr, 32'd16);

    // Misses insert bubbles
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h2222_2222, 1'b0, 1'b0, '0);
    check("miss_pc", bus.imemaddr, 32'd16);
    cycle(1'b1, 32'h3333_3333, 1'b0, 1'b0, '0);

    // Redirect overrides stall and discards wrong-path hit
    cycle(1'b1, 32'h4444_4444, 1'b1, 1'b1, 32'h0000_0100);
    check("redir_pc", bus.imemaddr, 32'h0000_0100);

    // HALT at 0x24, bubbles, then redirect out of HALTED
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0024);
    cycle(1'b1, HALT, 1'b0, 1'b0, '0);
    check("halt_pc", bus.imemaddr, 32'h0000_0028);
    check("halt_flag", {31'd0, bus.halted}, 32'd1);
    cycle(1'b1, 32'h5555_5555, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h5555_5555, 1'b1, 1'b0, '0);
    cycle(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0040);
    check("unhalt_pc", bus.imemaddr, 32'h0000_0040);
    cycle(1'b1, 32'h6666_6666, 1'b0, 1'b0, '0);

    // PC wrap and verbatim unaligned redirect
    cycle(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 32'h7777_7777, 1'b0, 1'b0, '0);
    check("wrap_pc", bus.imemaddr, 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0203);
    check("unaligned_pc", bus.imemaddr, 32'h0000_0203);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      cycle($urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? HALT : 32'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            32'($urandom) & 32'hFFFF_FFFC);
    end

    // Async reset while HALTED
    cycle(1'b1, HALT, 1'b0, 1'b0, '0);
    check("pre_rst_halted", {31'd0, bus.halted}, 32'd1);
    #1;
    do_reset();

`ifdef FETCH_PERF_EN
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h0000_1000, 1'b1, 1'b0, '0);
    cycle(1'b1, 32'h0000_1000, 1'b1, 1'b0, '0);
    cycle(1'b0, 32'h0000_1000, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    check("fetch_count", bus.fetch_count, 32'd5);
    check("stall_count", bus.stall_count, 32'd3);
    check("fetch_model", bus.fetch_count, m_fetch);
    check("stall_model", bus.stall_count, m_stall);
`else
    cycle(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    check("post_rst_pc", bus.imemaddr, RST_PC + 32'd4);
`endif

    @(negedge CLK); #1;
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
